resp_checker: RTL and testbench

//  Output-response analyzer for the gate-level fault-detection circuits: the receiving end of the

---
 rtl/resp_checker.sv | 74 +++++++
 tb/tb_resp_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/resp_checker.sv
// resp_checker: compares CUT responses, compacts them into a MISR and reports pass/fail per run
module resp_checker #(
    parameter int RESP_W = 1,
    parameter int NUM_VEC = 7,
    parameter int CNT_W = 4,
    parameter int SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY = 8'h1D,
    parameter logic [SIG_W-1:0] SEED = 8'h00,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    input  logic [RESP_W-1:0] exp_resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fault_det,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [SIG_W-1:0]  signature
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] vec_idx, cnt_next;
    logic [SIG_W-1:0] sig_next;
    logic go, accept, mism, last;
    always_comb begin
        go = start && state != RUN;
        accept = state == RUN && resp_valid;
        mism = resp !== exp_resp;
        last = vec_idx == CNT_W'(NUM_VEC - 1);
        sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
        cnt_next = mismatch_cnt + CNT_W'(mism);
    end
    // pass is decided from the next-state values so it is valid the same cycle done rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fault_det <= 1'b0;
            mismatch_cnt <= '0;
            first_fail_idx <= '1;
            signature <= SEED;
            vec_idx <= '0;
        end else if (go) begin
            state <= RUN;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            fault_det <= 1'b0;
            mismatch_cnt <= '0;
            first_fail_idx <= '1;
            signature <= SEED;
            vec_idx <= '0;
        end else if (accept) begin
            signature <= sig_next;
            mismatch_cnt <= cnt_next;
            fault_det <= fault_det | mism;
            first_fail_idx <= (mism && &first_fail_idx) ? vec_idx : first_fail_idx;
            vec_idx <= vec_idx + CNT_W'(1);
            if (last) begin
                state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
                pass <= cnt_next == '0 && sig_next == GOLDEN_SIG;
            end
        end
    end
endmodule

// File: tb/tb_resp_checker.sv
// tb_resp_checker: scoreboard bench for resp_checker; a second instance carries a wrong golden signature
module tb_resp_checker;
    localparam logic [6:0] T1 = 7'b1011001;
    localparam logic [6:0] EXP2 = 7'b1010111;

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic r);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, r};
    endfunction

    function automatic logic [7:0] misr(input logic [6:0] v);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 7; i++) s = misr_step(s, v[i]);
        return s;
    endfunction

    localparam logic [7:0] GOLD = misr(T1);

    logic clk = 0, rst_n = 0, start = 0, resp_valid = 0;
    logic [0:0] resp = '0, exp_resp = '0;
    logic a_busy, a_done, a_pass, a_fdet, b_busy, b_done, b_pass, b_fdet;
    logic [3:0] a_cnt, a_ffi, b_cnt, b_ffi;
    logic [7:0] a_sig, b_sig;

    always #5 clk = ~clk;

    resp_checker #(.GOLDEN_SIG(GOLD)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .exp_resp(exp_resp), .busy(a_busy), .done(a_done), .pass(a_pass), .fault_det(a_fdet),
        .mismatch_cnt(a_cnt), .first_fail_idx(a_ffi), .signature(a_sig));

    resp_checker #(.GOLDEN_SIG(GOLD ^ 8'h01)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .exp_resp(exp_resp), .busy(b_busy), .done(b_done), .pass(b_pass), .fault_det(b_fdet),
        .mismatch_cnt(b_cnt), .first_fail_idx(b_ffi), .signature(b_sig));

    typedef struct packed {
        logic [7:0] sig;
        logic [3:0] cnt;
        logic [3:0] ffi;
        logic fdet;
        logic fin;
    } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0;
    logic [7:0] m_sig;
    logic [3:0] m_cnt, m_ffi;
    logic m_fdet;
    int m_idx;

    task automatic test_reset(input logic mid_valid);
        resp_valid = mid_valid;
        resp = 1'b1;
        exp_resp = 1'b0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        resp_valid = 0;
        checks += 6;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
        if (a_pass !== 1'b0 || a_fdet !== 1'b0) begin errors++; $display("FAIL reset_pass_fdet: got %b%b want 00", a_pass, a_fdet); end
        if (a_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", a_cnt); end
        if (a_ffi !== 4'hF) begin errors++; $display("FAIL reset_ffi: got %h want f", a_ffi); end
        if (a_sig !== 8'h00) begin errors++; $display("FAIL reset_sig: got %h want 00", a_sig); end
    endtask

    task automatic test_idle_valid();
        resp_valid = 1;
        resp = 1'b1;
        exp_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resp_valid = 0;
        checks += 2;
        if (a_sig !== 8'h00 || a_cnt !== 4'h0) begin errors++; $display("FAIL idle_valid: got sig=%h cnt=%h want 00 0", a_sig, a_cnt); end
        if (a_busy !== 1'b0 || a_fdet !== 1'b0) begin errors++; $display("FAIL idle_state: got busy=%b fdet=%b want 0 0", a_busy, a_fdet); end
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        m_sig = 8'h00;
        m_cnt = 4'h0;
        m_ffi = 4'hF;
        m_fdet = 0;
        m_idx = 0;
        checks += 4;
        if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL start_busy_done: got %b%b want 10", a_busy, a_done); end
        if (a_sig !== 8'h00) begin errors++; $display("FAIL start_sig: got %h want 00", a_sig); end
        if (a_cnt !== 4'h0 || a_ffi !== 4'hF) begin errors++; $display("FAIL start_counters: got cnt=%h ffi=%h want 0 f", a_cnt, a_ffi); end
        if (a_fdet !== 1'b0 || a_pass !== 1'b0) begin errors++; $display("FAIL start_flags: got fdet=%b pass=%b want 0 0", a_fdet, a_pass); end
    endtask

    task automatic drive_vec(input logic r, input logic e, input int gap, input logic st);
        exp_t x;
        resp_valid = 0;
        repeat (gap) begin
            @(posedge clk); #1;
            checks++;
            if (a_done !== 1'b0 || a_sig !== m_sig) begin errors++; $display("FAIL gap_hold: got done=%b sig=%h want 0 %h", a_done, a_sig, m_sig); end
        end
        resp_valid = 1;
        resp = r;
        exp_resp = e;
        start = st;
        m_sig = misr_step(m_sig, r);
        if (r !== e) begin
            m_cnt++;
            m_fdet = 1;
            if (m_ffi == 4'hF) m_ffi = 4'(m_idx);
        end
        m_idx++;
        q.push_back('{m_sig, m_cnt, m_ffi, m_fdet, m_idx == 7});
        @(posedge clk); #1;
        resp_valid = 0;
        start = 0;
        x = q.pop_front();
        checks += 5;
        if (a_sig !== x.sig) begin errors++; $display("FAIL vec_sig: got %h want %h", a_sig, x.sig); end
        if (a_cnt !== x.cnt) begin errors++; $display("FAIL vec_cnt: got %h want %h", a_cnt, x.cnt); end
        if (a_ffi !== x.ffi) begin errors++; $display("FAIL vec_ffi: got %h want %h", a_ffi, x.ffi); end
        if (a_fdet !== x.fdet) begin errors++; $display("FAIL vec_fdet: got %b want %b", a_fdet, x.fdet); end
        if (a_done !== x.fin || a_busy !== !x.fin) begin errors++; $display("FAIL vec_done_busy: got %b%b want %b%b", a_done, a_busy, x.fin, !x.fin); end
        if (x.fin) begin
            checks += 3;
            if (a_pass !== (x.cnt == 0 && x.sig == GOLD)) begin errors++; $display("FAIL pass_a: got %b want %b", a_pass, x.cnt == 0 && x.sig == GOLD); end
            if (b_pass !== (x.cnt == 0 && x.sig == (GOLD ^ 8'h01))) begin errors++; $display("FAIL pass_b: got %b want %b", b_pass, x.cnt == 0 && x.sig == (GOLD ^ 8'h01)); end
            if (b_done !== 1'b1 || b_cnt !== x.cnt || b_fdet !== x.fdet) begin errors++; $display("FAIL status_b: got done=%b cnt=%h fdet=%b want 1 %h %b", b_done, b_cnt, b_fdet, x.cnt, x.fdet); end
        end
    endtask

    task automatic run(input logic [6:0] r, input logic [6:0] e, input int maxgap, input int start_at);
        for (int i = 0; i < 7; i++)
            drive_vec(r[i], e[i], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0, i == start_at);
    endtask

    task automatic test_clean();
        do_start();
        run(T1, T1, 0, -1);
        checks++;
        if (a_sig !== GOLD || a_pass !== 1'b1) begin errors++; $display("FAIL clean_final: got sig=%h pass=%b want %h 1", a_sig, a_pass, GOLD); end
    endtask

    task automatic test_done_hold();
        resp_valid = 1;
        resp = 1'b1;
        exp_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resp_valid = 0;
        checks += 2;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL done_hold: got done=%b busy=%b want 1 0", a_done, a_busy); end
        if (a_sig !== m_sig || a_cnt !== m_cnt) begin errors++; $display("FAIL done_ignore_valid: got sig=%h cnt=%h want %h %h", a_sig, a_cnt, m_sig, m_cnt); end
    endtask

    task automatic test_fault();
        do_start();
        run(7'h7F, EXP2, 0, -1);
        checks++;
        if (a_cnt !== 4'd2 || a_ffi !== 4'd3 || a_pass !== 1'b0) begin errors++; $display("FAIL fault_final: got cnt=%h ffi=%h pass=%b want 2 3 0", a_cnt, a_ffi, a_pass); end
    endtask

    task automatic test_gapped();
        do_start();
        run(T1, T1, 3, -1);
        checks++;
        if (a_sig !== GOLD || a_pass !== 1'b1) begin errors++; $display("FAIL gapped_final: got sig=%h pass=%b want %h 1", a_sig, a_pass, GOLD); end
    endtask

    task automatic test_start_in_run();
        do_start();
        run(T1, T1, 0, 2);
    endtask

    task automatic test_reset_mid_run();
        do_start();
        for (int i = 0; i < 4; i++) drive_vec(T1[i], T1[i], 0, 1'b0);
        test_reset(1'b1);
        test_clean();
    endtask

    initial begin
        test_reset(1'b0);
        test_idle_valid();
        test_clean();
        test_done_hold();
        test_fault();
        test_gapped();
        test_start_in_run();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
